display_scan_4dig: RTL and testbench
====================================

Name: display_scan_4dig

Overview:
- Four-digit 7-segment scanner sitting directly downstream of the frequency/current digit selector mux.
- Takes the four selected 4-bit digit codes and snapshots them once per frame, so a selector switch or value change never tears a frame.
- Time-multiplexes the digits onto active-low anode and segment lines, with dead time between digits and optional leading-zero blanking.

Parameters:
- REFRESH_DIV, 50000, clk cycles per digit slot; must be ≥ 2.
- BLANK_CYC, 16, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in_0  input  4  digit 0 code (least significant, rightmost)
- in_1  input  4  digit 1 code
- in_2  input  4  digit 2 code
- in_3  input  4  digit 3 code (most significant)
- dp_en  input  4  decimal point enable per digit, active high
- blank_lz  input  1  1 = enable leading-zero blanking
- an  output  4  anode enables, active low, one-hot-low
- seg  output  7  {g,f,e,d,c,b,a}, active low
- dp  output  1  decimal point, active low
- frame_tick  output  1  one-cycle pulse when the shadow registers load

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - Prescaler cnt = 0; digit index idx = 0.
  - Shadow digits sh_0..sh_3 = 0; shadow dp = 0; shadow blank_lz = 0.
  - an = 4'b1111, seg = 7'h7F, dp = 1, frame_tick = 0.
- Prescaler: cnt counts 0..REFRESH_DIV-1 and wraps. tick = (cnt == REFRESH_DIV-1).
- Index: on tick, idx advances 0→1→2→3→0.
- Snapshot:
  - On tick with idx==3, load in_0..in_3, dp_en and blank_lz into the shadow registers. This takes effect in the same cycle idx wraps to 0.
  - frame_tick pulses high for that one cycle (registered, so visible the cycle after the load edge).
  - Inputs are never sampled at any other time.
- Output registration: an, seg and dp are registered from idx, cnt and the shadows, so outputs follow the idx/cnt state with 1 clk latency.
- Dead time:
  - While cnt < BLANK_CYC (registered view), an = 4'b1111.
  - Otherwise an[idx] = 0 and all other bits are 1.
  - seg and dp are driven continuously; only the anodes are gated.
- Decode of sh_idx:
  - 0: 1000000, 1: 1111001, 2: 0100100, 3: 0110000, 4: 0011001
  - 5: 0010010, 6: 0000010, 7: 1111000, 8: 0000000, 9: 0010000
  - 10–14: 0111111 (dash, g only)
  - 15: 1111111 (blank)
- Leading-zero blanking (shadow blank_lz = 1):
  - digit k (k = 3, 2, 1) shows seg = 7'h7F when sh_k == 0 and all sh_j == 0 for j > k.
  - Digit 0 is never blanked.
  - Blanking does not suppress dp.
- dp = ~sh_dp[idx].
- Reset mid-scan: all state returns to reset values on the next edge; the scan restarts at idx 0 with an all-off.
- The first snapshot after reset occurs at the end of the first full frame (4×REFRESH_DIV cycles). Until then the shadows (zero) are displayed.

Test Plan:
- Set REFRESH_DIV=4, BLANK_CYC=1; hold reset 3 cycles → an=1111, seg=7F, dp=1, frame_tick=0 throughout. After release, an walks 1110, 1101, 1011, 0111 with the 4-cycle slot pattern (1 off + 3 on cycles) and repeats.
- in_3..in_0 = 1,2,3,4, blank_lz=0 → frame_tick pulses after cycle 16. The next frame shows seg 1111001 on an=0111, 0100100 on 1011, 0110000 on 1101, 0011001 on 1110.
- Change in_0 from 4 to 9 mid-frame → the current frame keeps showing 4. The new value 9 (0010000) appears only after the next frame_tick.
- in = 0,0,7,0 (in_3..in_0), blank_lz=1 → digits 3 and 2 blank (7F), digit 1 = 1111000, digit 0 = 1000000. With blank_lz=0, all four digits show their codes.
- in_0=12, in_1=15, dp_en=4'b0010 → digit 0 = 0111111 with dp=1; digit 1 = 1111111 with dp=0.
- Assert reset for 1 cycle while idx=2, cnt=2 → the next cycle has an=1111, seg=7F. The scan restarts at digit 0, and the shadows read 0 (digit 0 shows 1000000 when not in its dead time).

Source files
------------

// File: rtl/display_scan_4dig.sv
// Four-digit multiplexed 7-segment scanner with per-frame input snapshot,
// inter-digit dead time and optional leading-zero blanking. Outputs active low.
module display_scan_4dig #(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned BLANK_CYC   = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] in_0,
   input  logic [3:0] in_1,
   input  logic [3:0] in_2,
   input  logic [3:0] in_3,
   input  logic [3:0] dp_en,
   input  logic       blank_lz,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_tick
);

   localparam int unsigned CntW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

   logic [CntW-1:0]  cnt_q;
   logic [1:0]       idx_q;
   logic [3:0][3:0]  sh_q;
   logic [3:0]       sh_dp_q;
   logic             sh_blz_q;

   logic             tick;
   logic             load;
   logic [3:0]       cur;
   logic [3:0]       lead_zero;
   logic [3:0]       an_d;
   logic [6:0]       seg_d;
   logic             dp_d;

   assign tick = (cnt_q == CntW'(REFRESH_DIV - 1));
   assign load = tick && (idx_q == 2'd3);
   assign cur  = sh_q[idx_q];

   // lead_zero[k]: this digit and every more-significant digit are zero.
   always_comb begin
      lead_zero    = 4'b0000;
      lead_zero[3] = (sh_q[3] == 4'd0);
      lead_zero[2] = lead_zero[3] && (sh_q[2] == 4'd0);
      lead_zero[1] = lead_zero[2] && (sh_q[1] == 4'd0);
   end

   always_comb begin
      an_d = 4'b1111;
      if (cnt_q >= CntW'(BLANK_CYC)) begin
         an_d[idx_q] = 1'b0;
      end
   end

   always_comb begin
      case (cur)
         4'd0:    seg_d = 7'b1000000;
         4'd1:    seg_d = 7'b1111001;
         4'd2:    seg_d = 7'b0100100;
         4'd3:    seg_d = 7'b0110000;
         4'd4:    seg_d = 7'b0011001;
         4'd5:    seg_d = 7'b0010010;
         4'd6:    seg_d = 7'b0000010;
         4'd7:    seg_d = 7'b1111000;
         4'd8:    seg_d = 7'b0000000;
         4'd9:    seg_d = 7'b0010000;
         4'd15:   seg_d = 7'b1111111;
         default: seg_d = 7'b0111111;
      endcase
      if (sh_blz_q && lead_zero[idx_q]) begin
         seg_d = 7'b1111111;
      end
   end

   assign dp_d = ~sh_dp_q[idx_q];

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q      <= '0;
         idx_q      <= 2'd0;
         sh_q       <= '0;
         sh_dp_q    <= 4'b0000;
         sh_blz_q   <= 1'b0;
         an         <= 4'b1111;
         seg        <= 7'h7F;
         dp         <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         cnt_q <= tick ? '0 : cnt_q + CntW'(1);
         if (tick) begin
            idx_q <= idx_q + 2'd1;
         end
         if (load) begin
            sh_q     <= {in_3, in_2, in_1, in_0};
            sh_dp_q  <= dp_en;
            sh_blz_q <= blank_lz;
         end
         frame_tick <= load;
         an         <= an_d;
         seg        <= seg_d;
         dp         <= dp_d;
      end
   end

endmodule

// File: tb/tb_display_scan_4dig.sv
// Bench for display_scan_4dig: arithmetic reference model checked every cycle,
// table-driven frame vectors, and hand sequences for tearing and mid-scan reset.
module tb_display_scan_4dig;

   localparam int unsigned RD = 4;
   localparam int unsigned BC = 1;
   localparam int unsigned FRAME = 4 * RD;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] in_0, in_1, in_2, in_3, dp_en;
   logic       blank_lz;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       frame_tick;

   display_scan_4dig #(
      .REFRESH_DIV (RD),
      .BLANK_CYC   (BC)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_0       (in_0),
      .in_1       (in_1),
      .in_2       (in_2),
      .in_3       (in_3),
      .dp_en      (dp_en),
      .blank_lz   (blank_lz),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: elapsed cycles since reset plus the displayed snapshot.
   int unsigned m_t;
   logic [3:0]  m_sh [4];
   logic [3:0]  m_dp;
   logic        m_blz;

   typedef struct {
      logic [3:0][3:0] d;
      logic [3:0]      dpe;
      logic            blz;
      logic [3:0][6:0] s;
      logic [3:0]      dpo;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] digit_seg(input logic [3:0] v);
      case (v)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         4'd15:   return 7'b1111111;
         default: return 7'b0111111;
      endcase
   endfunction

   function automatic logic [6:0] model_seg(input int unsigned k);
      logic lead;
      lead = m_blz && (k != 0);
      for (int j = int'(k); j < 4; j++) begin
         if (m_sh[j] != 4'd0) lead = 1'b0;
      end
      return lead ? 7'h7F : digit_seg(m_sh[k]);
   endfunction

   // One clock: predict, advance, compare, then update the model.
   task automatic step();
      logic [3:0]  e_an;
      logic [6:0]  e_seg;
      logic        e_dp, e_ft, ld, r;
      int unsigned c, k;
      logic [3:0]  i0, i1, i2, i3, de;
      logic        bl;
      r  = reset;
      i0 = in_0; i1 = in_1; i2 = in_2; i3 = in_3; de = dp_en; bl = blank_lz;
      c  = m_t % RD;
      k  = (m_t / RD) % 4;
      ld = ((m_t % FRAME) == FRAME - 1);
      if (r) begin
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_ft = 1'b0;
      end else begin
         e_an = 4'hF;
         if (c >= BC) e_an[k] = 1'b0;
         e_seg = model_seg(k);
         e_dp  = ~m_dp[k];
         e_ft  = ld;
      end
      @(posedge clk);
      #1;
      check("model_an", an, e_an);
      check("model_seg", seg, e_seg);
      check("model_dp", dp, e_dp);
      check("model_frame_tick", frame_tick, e_ft);
      if (r) begin
         m_t = 0;
         for (int j = 0; j < 4; j++) m_sh[j] = 4'd0;
         m_dp = 4'd0; m_blz = 1'b0;
      end else begin
         if (ld) begin
            m_sh[0] = i0; m_sh[1] = i1; m_sh[2] = i2; m_sh[3] = i3;
            m_dp = de; m_blz = bl;
         end
         m_t++;
      end
   endtask

   task automatic wait_frame(input string name);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (frame_tick !== 1'b1 && n < int'(FRAME) + 2);
      check(name, frame_tick, 1);
   endtask

   task automatic set_in(input logic [3:0] d3, d2, d1, d0, input logic [3:0] de,
                         input logic bl);
      in_3 = d3; in_2 = d2; in_1 = d1; in_0 = d0; dp_en = de; blank_lz = bl;
   endtask

   initial begin
      m_t = 0; m_dp = 4'd0; m_blz = 1'b0;
      for (int j = 0; j < 4; j++) m_sh[j] = 4'd0;

      vecs[0] = '{{4'd1, 4'd2, 4'd3, 4'd4}, 4'b0000, 1'b0,
                  {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1111};
      vecs[1] = '{{4'd0, 4'd0, 4'd7, 4'd0}, 4'b0000, 1'b1,
                  {7'h7F, 7'h7F, 7'b1111000, 7'b1000000}, 4'b1111};
      vecs[2] = '{{4'd0, 4'd0, 4'd7, 4'd0}, 4'b0000, 1'b0,
                  {7'b1000000, 7'b1000000, 7'b1111000, 7'b1000000}, 4'b1111};
      vecs[3] = '{{4'd8, 4'd5, 4'd15, 4'd12}, 4'b0010, 1'b0,
                  {7'b0000000, 7'b0010010, 7'b1111111, 7'b0111111}, 4'b1101};
      vecs[4] = '{{4'd0, 4'd0, 4'd0, 4'd0}, 4'b1111, 1'b1,
                  {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b0000};
      vecs[5] = '{{4'd0, 4'd6, 4'd0, 4'd0}, 4'b1000, 1'b1,
                  {7'h7F, 7'b0000010, 7'b1000000, 7'b1000000}, 4'b0111};

      reset = 1'b1;
      set_in(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("reset_an", an, 4'hF);
         check("reset_seg", seg, 7'h7F);
      end
      reset = 1'b0;

      // Anode walk over the first frame; snapshot lands on its last cycle.
      for (int s = 0; s < int'(FRAME); s++) begin
         logic [3:0] ea;
         step();
         ea = 4'hF;
         if ((s % RD) >= BC) ea[s / RD] = 1'b0;
         check("walk_an", an, ea);
         check("first_frame_tick", frame_tick, (s == int'(FRAME) - 1));
      end

      foreach (vecs[v]) begin
         logic [3:0] seen;
         set_in(vecs[v].d[3], vecs[v].d[2], vecs[v].d[1], vecs[v].d[0],
                vecs[v].dpe, vecs[v].blz);
         wait_frame("vec_frame_tick");
         seen = 4'b0000;
         for (int i = 0; i < int'(FRAME); i++) begin
            step();
            for (int k = 0; k < 4; k++) begin
               if (an[k] == 1'b0) begin
                  check("vec_seg", seg, vecs[v].s[k]);
                  check("vec_dp", dp, vecs[v].dpo[k]);
                  seen[k] = 1'b1;
               end
            end
         end
         check("vec_digits_seen", seen, 4'hF);
      end

      // Changing an input mid-frame must not tear the displayed frame.
      set_in(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0);
      wait_frame("tear_frame_tick");
      wait_frame("tear_frame_tick2");
      step();
      step();
      in_0 = 4'd9;
      for (int i = 0; i < int'(FRAME) - 2; i++) begin
         step();
         if (an == 4'b1110) check("tear_old_digit", seg, 7'b0011001);
      end
      check("tear_new_frame_tick", frame_tick, 1);
      for (int i = 0; i < int'(RD); i++) begin
         step();
         if (an == 4'b1110) check("tear_new_digit", seg, 7'b0010000);
      end

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 7) == 0)
            set_in(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                   4'($urandom), 1'($urandom));
         reset = ($urandom_range(0, 99) == 0);
         step();
      end
      reset = 1'b0;

      // Reset mid-scan at idx 2, cnt 2.
      set_in(4'd5, 4'd5, 4'd5, 4'd5, 4'b1111, 1'b0);
      wait_frame("mid_frame_tick");
      begin
         int n;
         n = 0;
         while ((m_t % FRAME) != 2 * RD + 2 && n < int'(FRAME) + 2) begin
            step();
            n++;
         end
         check("mid_reach_state", m_t % FRAME, 2 * RD + 2);
         reset = 1'b1;
         step();
         reset = 1'b0;
         check("mid_reset_an", an, 4'hF);
         check("mid_reset_seg", seg, 7'h7F);
         n = 0;
         do begin
            step();
            n++;
         end while (an != 4'b1110 && n < int'(RD) + 2);
         check("mid_digit0_an", an, 4'b1110);
         check("mid_digit0_seg", seg, 7'b1000000);
         check("mid_digit0_dp", dp, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
